axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 slave memory model; sits directly downstream of the core's AXI master port (io_master_*).
- Serves both instruction fetch and LSU traffic from one on-chip word array.
- Independent read (AR/R) and write (AW/W/B) engines, with configurable response latency.
- Used in NPC simulation as the memory behind the core; the SoC memory replaces it in tape-out builds.

Parameters:
BASE_ADDR, 32'h8000_0000, first byte address mapped to the array
MEM_WORDS, 65536, array depth in 32-bit words
RD_DELAY, 2, idle cycles between the AR handshake and the first rvalid
WR_DELAY, 1, idle cycles between the last W handshake and bvalid

Ports:
clock  in  1  clock, rising edge
reset  in  1  synchronous, active-high
awvalid/awready  in/out  1/1  write address handshake
awaddr  in  32  write byte address
awid  in  4  write ID, echoed on bid
awlen  in  8  beats minus 1
awsize  in  3  bytes per beat, log2
awburst  in  2  burst type
wvalid/wready  in/out  1/1  write data handshake
wdata  in  32  write data
wstrb  in  4  byte lane enables
wlast  in  1  last write beat
bvalid/bready  out/in  1/1  write response handshake
bresp  out  2  write response
bid  out  4  latched awid
arvalid/arready  in/out  1/1  read address handshake
araddr  in  32  read byte address
arid  in  4  read ID, echoed on rid
arlen  in  8  beats minus 1
arsize  in  3  bytes per beat, log2
arburst  in  2  burst type
rvalid/rready  out/in  1/1  read data handshake
rdata  out  32  read data
rresp  out  2  read response
rlast  out  1  last read beat
rid  out  4  latched arid

Behaviour:
- Reset is synchronous and active-high; clock is `clock`.
- Outputs while reset is high, and after the reset edge: arready=0 and awready=0 while reset is high, 1 in idle afterwards. wready, bvalid, rvalid, rlast = 0. rdata = 0, rresp = 0, bresp = 0, rid = 0, bid = 0.
- Reset mid-burst returns both FSMs to idle and drops the transaction. Array contents are preserved.

Read FSM:
- States: R_IDLE, R_WAIT, R_DATA.
- R_IDLE: arready=1.
  - On arvalid&arready: latch addr, len, size, burst, id; load delay counter = RD_DELAY.
  - If RD_DELAY==0, load rdata at the same edge and go to R_DATA; otherwise go to R_WAIT.
- R_WAIT: counter decrements each cycle. When it reaches 1, rdata is loaded and the FSM goes to R_DATA.
- First rvalid appears exactly RD_DELAY+1 cycles after the AR handshake cycle.
- R_DATA:
  - rvalid=1; rlast=1 when beat==len.
  - rdata, rresp, rlast stay stable until rvalid&rready.
  - On the handshake, if last, go to R_IDLE (arready high next cycle). Otherwise advance the address and load the next word; rvalid stays high.
- Address advance:
  - INCR (2'b01) and WRAP (2'b10, treated as INCR): addr += (1<<size).
  - FIXED (2'b00): addr unchanged.
- Word index = (addr-BASE_ADDR)>>2. rdata always returns the full aligned word; the master selects the lanes.
- Out of range (addr<BASE_ADDR or index>=MEM_WORDS): rdata=0, rresp=2'b11 (DECERR). The burst length is still honoured.

Write FSM:
- States: W_IDLE, W_DATA, W_WAIT, W_RESP.
- W_IDLE: awready=1. On handshake: latch addr, len, size, burst, id; go to W_DATA.
- W_DATA: wready=1.
  - Each wvalid&wready writes the byte lanes enabled by wstrb at that edge, then advances the address using the read-side rule.
  - Out-of-range beats are dropped and set bresp=2'b11.
- Burst end is beat==awlen.
  - If wlast disagrees with the beat count on any beat, bresp=2'b10 (SLVERR) unless already DECERR.
  - After the final beat: go to W_WAIT if WR_DELAY>0, else W_RESP.
- W_RESP: bvalid=1 until bready; then go to W_IDLE.
  - bready is tied high on the core side, so bvalid is a single-cycle pulse.
- At most one outstanding transaction per direction; the next AW/AR is accepted only from idle.

Simultaneous events:
- Read and write engines run concurrently.
- A read word loaded on the same edge as a write to that word returns the old value.

Optional Feature:
- Macro: AXI_SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - Effective read delay = RD_DELAY + lfsr[2:0], sampled at the AR handshake.
  - Effective write delay = WR_DELAY + lfsr[5:3], sampled at the last W beat.
  - arready/awready in idle are additionally gated by lfsr[7].
- Undefined: fixed delays exactly as in Behaviour; no LFSR logic.

Test Plan:
- Preload word 0 = 32'h0000_0413. AR to 0x8000_0000, len 0, size 2, RD_DELAY=2 → rvalid 3 cycles after the handshake, rdata=32'h0000_0413, rlast=1, rresp=0.
- AW 0x8000_0004, W data 32'hDEAD_BEEF, wstrb 4'b0011, wlast=1; word previously 0 → bvalid after WR_DELAY+1 cycles, bresp=0. Readback gives 32'h0000_BEEF.
- Read burst at 0x8000_0010, arlen 3, INCR, size 2, rready toggled 1/0 → 4 beats of words 4..7, rlast only on beat 4, rdata held stable while rready=0.
- AR to 0x7FFF_FFFC → rdata=0, rresp=2'b11. AW to the same address → bresp=2'b11, array unchanged.
- AW with awlen=1 but wlast=1 on beat 1 → bresp=2'b10; both beats written.
- Assert reset during R_WAIT → rvalid never rises, arready=1 after reset drops, memory contents intact.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// ----------------------------------------------------------------------------
// axi_sram_slave_if
// AXI4 bus bundle between the core's memory master port and the SRAM model.
//   AW : awvalid/awready, awaddr, awid, awlen, awsize, awburst
//   W  : wvalid/wready, wdata, wstrb, wlast
//   B  : bvalid/bready, bresp, bid
//   AR : arvalid/arready, araddr, arid, arlen, arsize, arburst
//   R  : rvalid/rready, rdata, rresp, rlast, rid
// Modports: master (core side), slave (memory side).
// ----------------------------------------------------------------------------
interface axi_sram_slave_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// ----------------------------------------------------------------------------
// axi_sram_slave
// AXI4 slave memory model serving instruction fetch and LSU traffic from one
// 32-bit word array. Independent read (AR/R) and write (AW/W/B) engines, one
// outstanding transaction per direction, fixed response latency.
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; FSMs return to idle, array is kept
//   bus   : axi_sram_slave_if.slave (AW/W/B/AR/R channels)
//
// Parameters:
//   BASE_ADDR : first byte address mapped to word 0
//   MEM_WORDS : array depth in 32-bit words
//   RD_DELAY  : idle cycles between AR handshake and first rvalid
//   WR_DELAY  : idle cycles between last W handshake and bvalid
//
// Optional build macro AXI_SRAM_RAND_DELAY_EN: an 8-bit LFSR adds 0..7
// cycles to each delay and throttles arready/awready in idle.
// ----------------------------------------------------------------------------
module axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 65536,
    parameter int          RD_DELAY  = 2,
    parameter int          WR_DELAY  = 1
) (
    input  logic           clock,
    input  logic           reset,
    axi_sram_slave_if.slave bus
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_t;

    // NOTE: the array has no reset; contents must survive a reset and a
    // reset loop over it would not map onto a RAM macro.
    logic [31:0] mem [MEM_WORDS];

    // FIXED keeps the address; INCR and WRAP both step by the beat size.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
    endfunction

    function automatic logic in_range(input logic [31:0] addr);
        return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> 2) < 32'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    // ------------------------------------------------------------------
    // Delay and ready shaping
    // ------------------------------------------------------------------
    logic [15:0] rd_delay_eff;
    logic [15:0] wr_delay_eff;
    logic        ready_gate;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_next;

    // Fibonacci taps 8,6,5,4.
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_ff @(posedge clock) begin
        if (reset) lfsr <= 8'hA5;
        else       lfsr <= lfsr_next;
    end

    assign rd_delay_eff = 16'(RD_DELAY) + 16'(lfsr[2:0]);
    assign wr_delay_eff = 16'(WR_DELAY) + 16'(lfsr[5:3]);
    // Ready is registered, so look one step ahead to line up with lfsr[7].
    assign ready_gate   = lfsr_next[7];
`else
    assign rd_delay_eff = 16'(RD_DELAY);
    assign wr_delay_eff = 16'(WR_DELAY);
    assign ready_gate   = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_t   rd_state;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic [7:0]  rd_beat;
    logic [2:0]  rd_size;
    logic [1:0]  rd_burst;
    logic [15:0] rd_cnt;
    logic        arready_q;
    logic        rvalid_q;
    logic        rlast_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [3:0]  rid_q;

    logic        ar_fire;
    logic        r_fire;
    logic        rd_load;
    logic [31:0] rd_load_addr;

    assign ar_fire = bus.arvalid && arready_q;
    assign r_fire  = rvalid_q && bus.rready;

    // Which address (if any) feeds rdata at the coming edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        rd_load      = 1'b0;
        rd_load_addr = rd_addr;
        case (rd_state)
            R_IDLE: begin
                rd_load      = ar_fire && (rd_delay_eff == 16'd0);
                rd_load_addr = bus.araddr;
            end
            R_WAIT: rd_load = (rd_cnt == 16'd1);
            R_DATA: begin
                rd_load      = r_fire && !rlast_q;
                rd_load_addr = next_addr(rd_addr, rd_size, rd_burst);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so a read load
    // on the same edge as a write to that word sees the old contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (rd_load) begin
            // Always the full aligned word; the master picks the lanes.
            rdata_q <= in_range(rd_load_addr) ? mem[word_idx(rd_load_addr)] : '0;
            rresp_q <= in_range(rd_load_addr) ? RESP_OKAY : RESP_DECERR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state  <= R_IDLE;
            rd_addr   <= '0;
            rd_len    <= '0;
            rd_beat   <= '0;
            rd_size   <= '0;
            rd_burst  <= '0;
            rd_cnt    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready_q <= ready_gate;
                    if (ar_fire) begin
                        arready_q <= 1'b0;
                        rd_addr   <= bus.araddr;
                        rd_len    <= bus.arlen;
                        rd_size   <= bus.arsize;
                        rd_burst  <= bus.arburst;
                        rid_q     <= bus.arid;
                        rd_beat   <= '0;
                        rd_cnt    <= rd_delay_eff;
                        if (rd_delay_eff == 16'd0) begin
                            rvalid_q <= 1'b1;
                            rlast_q  <= (bus.arlen == 8'd0);
                            rd_state <= R_DATA;
                        end else begin
                            rd_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (rd_cnt == 16'd1) begin
                        rvalid_q <= 1'b1;
                        rlast_q  <= (rd_len == 8'd0);
                        rd_state <= R_DATA;
                    end else begin
                        rd_cnt <= rd_cnt - 16'd1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= ready_gate;
                            rd_state  <= R_IDLE;
                        end else begin
                            rd_addr <= rd_load_addr;
                            rd_beat <= rd_beat + 8'd1;
                            rlast_q <= ((rd_beat + 8'd1) == rd_len);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rid     = rid_q;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_t   wr_state;
    logic [31:0] wr_addr;
    logic [7:0]  wr_len;
    logic [7:0]  wr_beat;
    logic [2:0]  wr_size;
    logic [1:0]  wr_burst;
    logic [15:0] wr_cnt;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic [3:0]  bid_q;

    logic        aw_fire;
    logic        w_fire;
    logic        b_fire;
    logic        wr_hit;
    logic        wr_last_beat;
    logic [1:0]  wr_resp_next;

    assign aw_fire      = bus.awvalid && awready_q;
    assign w_fire       = bus.wvalid && wready_q;
    assign b_fire       = bvalid_q && bus.bready;
    assign wr_hit       = in_range(wr_addr);
    assign wr_last_beat = (wr_beat == wr_len);

    // Response accumulates over the burst: DECERR dominates SLVERR.
    always_comb begin
        wr_resp_next = bresp_q;
        if (!wr_hit)
            wr_resp_next = RESP_DECERR;
        else if ((bus.wlast != wr_last_beat) && (bresp_q != RESP_DECERR))
            wr_resp_next = RESP_SLVERR;
    end

    always_ff @(posedge clock) begin
        if (!reset && w_fire && wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state  <= W_IDLE;
            wr_addr   <= '0;
            wr_len    <= '0;
            wr_beat   <= '0;
            wr_size   <= '0;
            wr_burst  <= '0;
            wr_cnt    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    awready_q <= ready_gate;
                    if (aw_fire) begin
                        awready_q <= 1'b0;
                        wr_addr   <= bus.awaddr;
                        wr_len    <= bus.awlen;
                        wr_size   <= bus.awsize;
                        wr_burst  <= bus.awburst;
                        bid_q     <= bus.awid;
                        wr_beat   <= '0;
                        bresp_q   <= RESP_OKAY;
                        wready_q  <= 1'b1;
                        wr_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        bresp_q <= wr_resp_next;
                        wr_addr <= next_addr(wr_addr, wr_size, wr_burst);
                        wr_beat <= wr_beat + 8'd1;
                        // Burst length comes from awlen, not from wlast.
                        if (wr_last_beat) begin
                            wready_q <= 1'b0;
                            if (wr_delay_eff == 16'd0) begin
                                bvalid_q <= 1'b1;
                                wr_state <= W_RESP;
                            end else begin
                                wr_cnt   <= wr_delay_eff;
                                wr_state <= W_WAIT;
                            end
                        end
                    end
                end
                W_WAIT: begin
                    if (wr_cnt == 16'd1) begin
                        bvalid_q <= 1'b1;
                        wr_state <= W_RESP;
                    end else begin
                        wr_cnt <= wr_cnt - 16'd1;
                    end
                end
                W_RESP: begin
                    if (b_fire) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= ready_gate;
                        wr_state  <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed scenarios followed by randomized AXI read/write bursts, checked
// against a word-addressed reference memory held in an associative array.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_axi_sram_slave;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          MEM_WORDS = 65536;
    localparam int          RD_DELAY  = 2;
    localparam int          WR_DELAY  = 1;
    localparam int          TMO       = 200;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    axi_sram_slave_if bus ();

    axi_sram_slave #(
        .BASE_ADDR (BASE),
        .MEM_WORDS (MEM_WORDS),
        .RD_DELAY  (RD_DELAY),
        .WR_DELAY  (WR_DELAY)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_hit(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < longint'(MEM_WORDS) * 4);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int b,
                                              input logic [2:0] size, input logic [1:0] burst);
        if (burst == 2'b00) return start;
        return start + 32'(b) * (32'd1 << size);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_hit(a)) return 32'h0;
        if (!ref_mem.exists(model_idx(a))) return 32'h0;
        return ref_mem[model_idx(a)];
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = model_read(a);
        for (int l = 0; l < 4; l++) if (s[l]) w[8*l +: 8] = d[8*l +: 8];
        ref_mem[model_idx(a)] = w;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int bad_beat);
        int k;
        int lat;
        bit any_dec;
        bit any_mis;
        logic [1:0] exp_resp;
        any_dec = 0;
        any_mis = 0;
        for (int b = 0; b <= int'(len); b++) begin
            if (!model_hit(beat_addr(addr, b, size, burst))) any_dec = 1;
            else model_write(beat_addr(addr, b, size, burst), wd[b], ws[b]);
            if (b == bad_beat) any_mis = 1;
        end
        exp_resp = any_dec ? 2'b11 : (any_mis ? 2'b10 : 2'b00);

        @(negedge clock);
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awid    = id;
        k = 0;
        while (!bus.awready && k < TMO) begin @(negedge clock); k++; end
        check("awready", 32'(bus.awready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = wd[b];
            bus.wstrb  = ws[b];
            bus.wlast  = (b == int'(len)) != (b == bad_beat);
            k = 0;
            while (!bus.wready && k < TMO) begin @(negedge clock); k++; end
            check("wready", 32'(bus.wready), 32'd1);
            @(posedge clock);
            @(negedge clock);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        lat = 1;
        while (!bus.bvalid && lat < TMO) begin @(negedge clock); lat++; end
        check("b_latency", 32'(lat), 32'(WR_DELAY + 1));
        check("bresp", 32'(bus.bresp), 32'(exp_resp));
        check("bid", 32'(bus.bid), 32'(id));
        @(negedge clock);
        check("bvalid_pulse", 32'(bus.bvalid), 32'd0);
        check("awready_idle", 32'(bus.awready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit toggle);
        int k;
        int lat;
        logic [31:0] a;
        @(negedge clock);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arid    = id;
        k = 0;
        while (!bus.arready && k < TMO) begin @(negedge clock); k++; end
        check("arready", 32'(bus.arready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.arvalid = 1'b0;
        lat = 1;
        while (!bus.rvalid && lat < TMO) begin @(negedge clock); lat++; end
        check("r_latency", 32'(lat), 32'(RD_DELAY + 1));
        for (int b = 0; b <= int'(len); b++) begin
            a = beat_addr(addr, b, size, burst);
            k = 0;
            while (!bus.rvalid && k < TMO) begin @(negedge clock); k++; end
            if (toggle && (b % 2 == 1)) begin
                bus.rready = 1'b0;
                check("hold_rdata", bus.rdata, model_read(a));
                check("hold_rlast", 32'(bus.rlast), 32'(b == int'(len)));
                @(negedge clock);
            end
            bus.rready = 1'b1;
            check("rvalid", 32'(bus.rvalid), 32'd1);
            check("rdata", bus.rdata, model_read(a));
            check("rresp", 32'(bus.rresp), model_hit(a) ? 32'd0 : 32'd3);
            check("rlast", 32'(bus.rlast), 32'(b == int'(len)));
            check("rid", 32'(bus.rid), 32'(id));
            @(posedge clock);
            @(negedge clock);
            bus.rready = 1'b0;
        end
        check("rvalid_drop", 32'(bus.rvalid), 32'd0);
        check("arready_idle", 32'(bus.arready), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500_000;
        $display("FAIL watchdog: observed no completion expected finish within time limit");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          bad;
        int          sel;

        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
        bus.awsize  = '0;   bus.awburst = '0;
        bus.wvalid  = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready  = 1'b1;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
        bus.arsize  = '0;   bus.arburst = '0;
        bus.rready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'({bus.arready, bus.awready, bus.wready}), 32'd0);
        check("rst_valid", 32'({bus.bvalid, bus.rvalid, bus.rlast}), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_resp", 32'({bus.rresp, bus.bresp}), 32'd0);
        check("rst_ids", 32'({bus.rid, bus.bid}), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("idle_ready", 32'({bus.arready, bus.awready}), 32'd3);

        // Fill words 0..31 and the top two words of the array
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(BASE, 8'd15, 3'd2, 2'b01, 4'd1, -1);
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(BASE + 32'h40, 8'd15, 3'd2, 2'b01, 4'd2, -1);
        wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(BASE + 32'h3_FFF8, 8'd1, 3'd2, 2'b01, 4'd3, -1);

        // Word 0 = 0x413, single-beat read
        wd[0] = 32'h0000_0413; ws[0] = 4'hF;
        do_write(BASE, 8'd0, 3'd2, 2'b01, 4'd4, -1);
        do_read(BASE, 8'd0, 3'd2, 2'b01, 4'd5, 1'b0);

        // Partial-strobe write onto a zero word
        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd6, -1);
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'b0011;
        do_write(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd7, -1);
        do_read(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd8, 1'b0);
        check("beef_model", model_read(BASE + 32'h4), 32'h0000_BEEF);

        // INCR burst with rready throttling
        do_read(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'd9, 1'b1);

        // Below the mapped range
        do_read(32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 4'd10, 1'b0);
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write(32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 4'd11, -1);
        do_read(BASE, 8'd7, 3'd2, 2'b01, 4'd12, 1'b0);

        // wlast early on a two-beat burst: both beats still land
        wd[0] = 32'hA5A5_0001; wd[1] = 32'h5A5A_0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(BASE + 32'h40, 8'd1, 3'd2, 2'b01, 4'd13, 0);
        do_read(BASE + 32'h40, 8'd1, 3'd2, 2'b01, 4'd14, 1'b0);

        // Reset while the read engine is counting down
        @(negedge clock);
        bus.arvalid = 1'b1; bus.araddr = BASE + 32'h8; bus.arlen = 8'd0;
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = 4'd15;
        k = 0;
        while (!bus.arready && k < TMO) begin @(negedge clock); k++; end
        check("rst_test_arready", 32'(bus.arready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.arvalid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        check("midrst_arready", 32'(bus.arready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("postrst_rvalid", 32'(bus.rvalid), 32'd0);
        end
        check("postrst_arready", 32'(bus.arready), 32'd1);
        do_read(BASE, 8'd3, 3'd2, 2'b01, 4'd1, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            sel = int'($urandom_range(0, 7));
            if (sel <= 5)      addr = BASE + (32'($urandom_range(0, 27)) << 2) + 32'($urandom_range(0, 3));
            else if (sel == 6) addr = 32'h7FFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else               addr = BASE + 32'h3_FFF8 + (32'($urandom_range(0, 1)) << 2);
            len   = 8'($urandom_range(0, 3));
            size  = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len))) : -1;
                do_write(addr, len, size, burst, 4'($urandom), bad);
            end else begin
                do_read(addr, len, size, burst, 4'($urandom), 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
